// File: rtl/sample_uart_streamer_pkg.sv
// Shared definitions for the sample UART streamer: frame constants,
// FSM state encoding and the bytes-per-sample helper.
package sample_uart_streamer_pkg;

  localparam int UART_BITS = 10;
  localparam logic [7:0] HEADER_DEFAULT = 8'hA5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    HDR  = 2'd2,
    DATA = 2'd3
  } state_t;

  function automatic int nbytes(input int width);
    return (width + 7) / 8;
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serialiser. Ready is also high during the last stop-bit cycle, so a
// Start accepted there begins the next start bit with no idle gap.
module uart_tx_byte
  import sample_uart_streamer_pkg::*;
#(
  parameter int ClkDiv = 434
) (
  input  logic       nReset,
  input  logic       Clk,
  input  logic [7:0] Data,
  input  logic       Start,
  output logic       Tx,
  output logic       Ready
);

  localparam int CW = $clog2(ClkDiv);

  logic          busy;
  logic [CW-1:0] cnt;
  logic [3:0]    bit_idx;
  logic [8:0]    shift;
  logic          last_cycle;

  assign last_cycle = busy && (bit_idx == 4'(UART_BITS - 1)) && (cnt == CW'(ClkDiv - 1));
  assign Ready      = !busy || last_cycle;

  // shift holds the bits still to go out after the current one (data LSB first, then stop)
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      busy    <= 1'b0;
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '1;
      Tx      <= 1'b1;
    end else if (Start && Ready) begin
      busy    <= 1'b1;
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= {1'b1, Data};
      Tx      <= 1'b0;
    end else if (busy) begin
      if (cnt == CW'(ClkDiv - 1)) begin
        cnt <= '0;
        if (bit_idx == 4'(UART_BITS - 1)) begin
          busy <= 1'b0;
          Tx   <= 1'b1;
        end else begin
          bit_idx <= bit_idx + 4'd1;
          Tx      <= shift[0];
          shift   <= {1'b1, shift[8:1]};
        end
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/sample_uart_streamer.sv
// Buffers decimated samples in a small FIFO and streams each one as a UART
// frame: header byte, then the sign-extended sample MSB byte first.
module sample_uart_streamer
  import sample_uart_streamer_pkg::*;
#(
  parameter int         n      = 18,
  parameter int         ClkDiv = 434,
  parameter int         FifoAW = 3,
  parameter logic [7:0] Header = HEADER_DEFAULT
) (
  input  logic         Clk,
  input  logic         nReset,
  input  logic [n-1:0] Input,
  input  logic         Valid,
  output logic         Tx,
  output logic         Busy,
  output logic         Overflow
);

  localparam int NB     = nbytes(n);
  localparam int WORD_W = 8 * NB;
  localparam int DEPTH  = 2 ** FifoAW;
  localparam int IDX_W  = (NB > 1) ? $clog2(NB) : 1;

  logic [n-1:0]      mem [DEPTH];
  logic [FifoAW-1:0] wr_ptr, rd_ptr;
  logic [FifoAW:0]   count;
  logic              full, empty, push, pop;

  state_t             state, state_next;
  logic [IDX_W-1:0]   idx, idx_next, byte_sel;
  logic [WORD_W-1:0]  sample_word;
  logic               send_header, tx_start, tx_ready;
  logic [7:0]         tx_data;

  assign full  = (count == (FifoAW + 1)'(DEPTH));
  assign empty = (count == '0);
  // full is judged before any pop this cycle, so a simultaneous pop never rescues the write
  assign push  = Valid && !full;

  always_ff @(posedge Clk) begin
    if (push) mem[wr_ptr] <= Input;
  end

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      Overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + FifoAW'(1);
      if (pop)  rd_ptr <= rd_ptr + FifoAW'(1);
      case ({push, pop})
        2'b10:   count <= count + (FifoAW + 1)'(1);
        2'b01:   count <= count - (FifoAW + 1)'(1);
        default: count <= count;
      endcase
      if (Valid && full) Overflow <= 1'b1;
    end
  end

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      state       <= IDLE;
      idx         <= '0;
      sample_word <= '0;
      Busy        <= 1'b0;
    end else begin
      state <= state_next;
      idx   <= idx_next;
      if (pop) sample_word <= WORD_W'($signed(mem[rd_ptr]));
      Busy  <= (state != IDLE) || !empty;
    end
  end

  // The pop and the header Start coincide with the previous stop-bit end, keeping frames contiguous
  always_comb begin
    state_next  = state;
    idx_next    = idx;
    pop         = 1'b0;
    tx_start    = 1'b0;
    send_header = 1'b1;
    byte_sel    = idx - IDX_W'(1);
    case (state)
      IDLE: begin
        if (!empty) begin
          pop        = 1'b1;
          state_next = LOAD;
        end
      end
      LOAD: begin
        tx_start   = tx_ready;
        state_next = HDR;
      end
      HDR: begin
        if (tx_ready) begin
          tx_start    = 1'b1;
          send_header = 1'b0;
          byte_sel    = IDX_W'(NB - 1);
          idx_next    = IDX_W'(NB - 1);
          state_next  = DATA;
        end
      end
      DATA: begin
        if (tx_ready) begin
          if (idx != '0) begin
            tx_start    = 1'b1;
            send_header = 1'b0;
            idx_next    = idx - IDX_W'(1);
          end else if (!empty) begin
            pop        = 1'b1;
            tx_start   = 1'b1;
            state_next = LOAD;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign tx_data = send_header ? Header : 8'(sample_word >> {byte_sel, 3'b000});

  uart_tx_byte #(
    .ClkDiv(ClkDiv)
  ) u_tx (
    .nReset(nReset),
    .Clk   (Clk),
    .Data  (tx_data),
    .Start (tx_start),
    .Tx    (Tx),
    .Ready (tx_ready)
  );

endmodule
